// File: rtl/rv_ex_stage_pkg.sv
// Shared constants and ALU op encoding for the dv-cpu-rv execute stage.
package rv_ex_stage_pkg;

    localparam int MXLEN     = 32;
    localparam int REG_IDX_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_op_e;

endpackage

// File: rtl/rv_alu.sv
// Combinational integer ALU; unused op encodings produce zero.
module rv_alu
    import rv_ex_stage_pkg::*;
#(
    parameter int XLEN = MXLEN
) (
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;
    assign shamt = b[SHW-1:0];

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << shamt;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/rv_fwd_mux.sv
// Operand forwarding select: EX/MEM register, then MEM, then WB, then captured data.
module rv_fwd_mux
    import rv_ex_stage_pkg::*;
#(
    parameter int XLEN = MXLEN
) (
    input  logic [REG_IDX_W-1:0] rs,
    input  logic [XLEN-1:0]      captured,
    input  logic                 s2_valid,
    input  logic                 s2_wb_en,
    input  logic [REG_IDX_W-1:0] s2_rd,
    input  logic [XLEN-1:0]      s2_data,
    input  logic                 fmem_valid,
    input  logic [REG_IDX_W-1:0] fmem_rd,
    input  logic [XLEN-1:0]      fmem_data,
    input  logic                 fwb_valid,
    input  logic [REG_IDX_W-1:0] fwb_rd,
    input  logic [XLEN-1:0]      fwb_data,
    output logic [XLEN-1:0]      data
);

    // x0 is hardwired to zero, so it never takes a forwarded value
    always_comb begin
        data = captured;
        if (rs != '0) begin
            if (s2_valid && s2_wb_en && (s2_rd == rs)) begin
                data = s2_data;
            end else if (fmem_valid && (fmem_rd == rs)) begin
                data = fmem_data;
            end else if (fwb_valid && (fwb_rd == rs)) begin
                data = fwb_data;
            end
        end
    end

endmodule

// File: rtl/rv_ex_stage.sv
// Execute stage: ID/EX register, forwarded operand select, ALU, EX/MEM register.
module rv_ex_stage
    import rv_ex_stage_pkg::*;
#(
    parameter int XLEN = MXLEN
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 id_valid_i,
    output logic                 ex_ready_o,
    input  logic [XLEN-1:0]      id_pc_i,
    input  logic [REG_IDX_W-1:0] id_rs1_i,
    input  logic [REG_IDX_W-1:0] id_rs2_i,
    input  logic [REG_IDX_W-1:0] id_rd_i,
    input  logic [XLEN-1:0]      id_rs1_data_i,
    input  logic [XLEN-1:0]      id_rs2_data_i,
    input  logic [XLEN-1:0]      id_imm_i,
    input  logic [3:0]           id_alu_op_i,
    input  logic                 id_src1_pc_i,
    input  logic                 id_src2_imm_i,
    input  logic                 id_wb_en_i,
    input  logic                 fmem_valid_i,
    input  logic [REG_IDX_W-1:0] fmem_rd_i,
    input  logic [XLEN-1:0]      fmem_data_i,
    input  logic                 fwb_valid_i,
    input  logic [REG_IDX_W-1:0] fwb_rd_i,
    input  logic [XLEN-1:0]      fwb_data_i,
    output logic                 mem_valid_o,
    input  logic                 mem_ready_i,
    output logic [XLEN-1:0]      mem_pc_o,
    output logic [XLEN-1:0]      mem_result_o,
    output logic [XLEN-1:0]      mem_rs2_data_o,
    output logic [REG_IDX_W-1:0] mem_rd_o,
    output logic                 mem_wb_en_o
);

    logic                 s1_valid, s1_src1_pc, s1_src2_imm, s1_wb_en;
    logic [XLEN-1:0]      s1_pc, s1_rs1_data, s1_rs2_data, s1_imm;
    logic [REG_IDX_W-1:0] s1_rs1, s1_rs2, s1_rd;
    logic [3:0]           s1_alu_op;

    logic                 s2_valid, s2_wb_en;
    logic [XLEN-1:0]      s2_pc, s2_result, s2_rs2_data;
    logic [REG_IDX_W-1:0] s2_rd;

    logic            s2_adv, s1_load, s1_hold;
    logic [XLEN-1:0] fwd_rs1, fwd_rs2, op1, op2, alu_result;

    assign s2_adv     = s1_valid & (~s2_valid | mem_ready_i);
    assign ex_ready_o = ~s1_valid | s2_adv;
    assign s1_load    = id_valid_i & ex_ready_o & ~flush_i;
    assign s1_hold    = s1_valid & ~s2_adv;

    rv_fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
        .rs(s1_rs1), .captured(s1_rs1_data),
        .s2_valid(s2_valid), .s2_wb_en(s2_wb_en), .s2_rd(s2_rd), .s2_data(s2_result),
        .fmem_valid(fmem_valid_i), .fmem_rd(fmem_rd_i), .fmem_data(fmem_data_i),
        .fwb_valid(fwb_valid_i), .fwb_rd(fwb_rd_i), .fwb_data(fwb_data_i),
        .data(fwd_rs1)
    );

    rv_fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
        .rs(s1_rs2), .captured(s1_rs2_data),
        .s2_valid(s2_valid), .s2_wb_en(s2_wb_en), .s2_rd(s2_rd), .s2_data(s2_result),
        .fmem_valid(fmem_valid_i), .fmem_rd(fmem_rd_i), .fmem_data(fmem_data_i),
        .fwb_valid(fwb_valid_i), .fwb_rd(fwb_rd_i), .fwb_data(fwb_data_i),
        .data(fwd_rs2)
    );

    assign op1 = s1_src1_pc  ? s1_pc  : fwd_rs1;
    assign op2 = s1_src2_imm ? s1_imm : fwd_rs2;

    rv_alu #(.XLEN(XLEN)) u_alu (
        .op(s1_alu_op), .a(op1), .b(op2), .result(alu_result)
    );

    // WB data is only presented for one cycle, so a stalled S1 snoops it into its captured operands
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid    <= 1'b0;
            s1_pc       <= '0;
            s1_rs1      <= '0;
            s1_rs2      <= '0;
            s1_rd       <= '0;
            s1_rs1_data <= '0;
            s1_rs2_data <= '0;
            s1_imm      <= '0;
            s1_alu_op   <= '0;
            s1_src1_pc  <= 1'b0;
            s1_src2_imm <= 1'b0;
            s1_wb_en    <= 1'b0;
        end else begin
            if (flush_i)      s1_valid <= 1'b0;
            else if (s1_load) s1_valid <= 1'b1;
            else if (s2_adv)  s1_valid <= 1'b0;

            if (s1_load) begin
                s1_pc       <= id_pc_i;
                s1_rs1      <= id_rs1_i;
                s1_rs2      <= id_rs2_i;
                s1_rd       <= id_rd_i;
                s1_rs1_data <= id_rs1_data_i;
                s1_rs2_data <= id_rs2_data_i;
                s1_imm      <= id_imm_i;
                s1_alu_op   <= id_alu_op_i;
                s1_src1_pc  <= id_src1_pc_i;
                s1_src2_imm <= id_src2_imm_i;
                s1_wb_en    <= id_wb_en_i;
            end else if (s1_hold) begin
                if (fwb_valid_i && (fwb_rd_i == s1_rs1) && (s1_rs1 != '0)) s1_rs1_data <= fwb_data_i;
                if (fwb_valid_i && (fwb_rd_i == s1_rs2) && (s1_rs2 != '0)) s1_rs2_data <= fwb_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s2_valid    <= 1'b0;
            s2_pc       <= '0;
            s2_result   <= '0;
            s2_rs2_data <= '0;
            s2_rd       <= '0;
            s2_wb_en    <= 1'b0;
        end else begin
            if (flush_i)          s2_valid <= 1'b0;
            else if (s2_adv)      s2_valid <= 1'b1;
            else if (mem_ready_i) s2_valid <= 1'b0;

            if (s2_adv && !flush_i) begin
                s2_pc       <= s1_pc;
                s2_result   <= alu_result;
                s2_rs2_data <= fwd_rs2;
                s2_rd       <= s1_rd;
                s2_wb_en    <= s1_wb_en;
            end
        end
    end

    assign mem_valid_o    = s2_valid;
    assign mem_pc_o       = s2_pc;
    assign mem_result_o   = s2_result;
    assign mem_rs2_data_o = s2_rs2_data;
    assign mem_rd_o       = s2_rd;
    assign mem_wb_en_o    = s2_wb_en;

endmodule

// File: tb/tb_rv_ex_stage.sv
// Scoreboard bench for rv_ex_stage: an in-order architectural model predicts results while
// a bench-side MEM/WB pipeline and register file feed the forwarding and read ports.
module tb_rv_ex_stage;

    localparam int XLEN = 32;

    logic            clk_i = 1'b0;
    logic            rst_i, flush_i, id_valid_i, ex_ready_o;
    logic [XLEN-1:0] id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i;
    logic [4:0]      id_rs1_i, id_rs2_i, id_rd_i;
    logic [3:0]      id_alu_op_i;
    logic            id_src1_pc_i, id_src2_imm_i, id_wb_en_i;
    logic            fmem_valid_i, fwb_valid_i;
    logic [4:0]      fmem_rd_i, fwb_rd_i;
    logic [XLEN-1:0] fmem_data_i, fwb_data_i;
    logic            mem_valid_o, mem_ready_i, mem_wb_en_o;
    logic [XLEN-1:0] mem_pc_o, mem_result_o, mem_rs2_data_o;
    logic [4:0]      mem_rd_o;

    always #5 clk_i = ~clk_i;

    rv_ex_stage #(.XLEN(XLEN)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .id_valid_i(id_valid_i), .ex_ready_o(ex_ready_o),
        .id_pc_i(id_pc_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
        .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i),
        .id_alu_op_i(id_alu_op_i), .id_src1_pc_i(id_src1_pc_i), .id_src2_imm_i(id_src2_imm_i),
        .id_wb_en_i(id_wb_en_i),
        .fmem_valid_i(fmem_valid_i), .fmem_rd_i(fmem_rd_i), .fmem_data_i(fmem_data_i),
        .fwb_valid_i(fwb_valid_i), .fwb_rd_i(fwb_rd_i), .fwb_data_i(fwb_data_i),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
        .mem_pc_o(mem_pc_o), .mem_result_o(mem_result_o), .mem_rs2_data_o(mem_rs2_data_o),
        .mem_rd_o(mem_rd_o), .mem_wb_en_o(mem_wb_en_o)
    );

    typedef struct {
        logic [31:0] pc, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  op;
        logic        s1pc, s2imm, wb;
    } instr_t;

    typedef struct {
        logic [31:0] pc, result, rs2_data, prev;
        logic [4:0]  rd;
        logic        wb_en;
        int          acc_cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] arch_rf [32] = '{default: 32'h0};
    logic [31:0] phys_rf [32] = '{default: 32'h0};
    logic        m_valid = 1'b0, w_valid = 1'b0;
    logic [4:0]  m_rd = 5'd0, w_rd = 5'd0;
    logic [31:0] m_data = 32'h0, w_data = 32'h0;
    logic        fire_now = 1'b0, fire_wb = 1'b0;
    logic [4:0]  fire_rd = 5'd0;
    logic [31:0] fire_data = 32'h0;
    int          cyc = 0;
    int          n_checks = 0, n_pass = 0;
    logic [3:0]  op_tab [10] = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
                                 4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111};

    // Architectural ALU semantics in plain arithmetic
    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (op)
            4'b0000: return a + b;
            4'b1000: return a - b;
            4'b0001: return a << sh;
            4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: return (a < b) ? 32'd1 : 32'd0;
            4'b0100: return a ^ b;
            4'b0101: return a >> sh;
            4'b1101: return $unsigned($signed(a) >>> sh);
            4'b0110: return a | b;
            4'b0111: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    // Register file read port in ID, with write-through of the retiring WB value
    function automatic logic [31:0] id_read(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (w_valid && (w_rd == r)) return w_data;
        return phys_rf[r];
    endfunction

    function automatic instr_t mk(input logic [3:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic [4:0] rd, input logic [31:0] imm, input logic s2imm);
        instr_t t;
        t.pc = 32'h1000 + {25'd0, rd, 2'b00};
        t.imm = imm; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.op = op;
        t.s1pc = 1'b0; t.s2imm = s2imm; t.wb = 1'b1;
        return t;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic rollback();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_back();
            if (e.wb_en && e.rd != 5'd0) arch_rf[e.rd] = e.prev;
        end
    endtask

    // One cycle of ID/MEM/WB stimulus; pushes the architectural expectation when EX accepts
    task automatic applyStimulus(input logic v, input instr_t in, input logic mr, input logic fl, output logic acc);
        exp_t        e;
        logic [31:0] a, b2;
        @(negedge clk_i);
        id_valid_i = v; id_pc_i = in.pc; id_rs1_i = in.rs1; id_rs2_i = in.rs2; id_rd_i = in.rd;
        id_rs1_data_i = id_read(in.rs1); id_rs2_data_i = id_read(in.rs2);
        id_imm_i = in.imm; id_alu_op_i = in.op; id_src1_pc_i = in.s1pc;
        id_src2_imm_i = in.s2imm; id_wb_en_i = in.wb;
        mem_ready_i = mr; flush_i = fl;
        fmem_valid_i = m_valid; fmem_rd_i = m_rd; fmem_data_i = m_data;
        fwb_valid_i = w_valid; fwb_rd_i = w_rd; fwb_data_i = w_data;
        #2;
        acc = v && ex_ready_o && !fl;
        if (acc) begin
            a  = in.s1pc ? in.pc : arch_rf[in.rs1];
            b2 = arch_rf[in.rs2];
            e.result   = alu_ref(in.op, a, in.s2imm ? in.imm : b2);
            e.pc       = in.pc;
            e.rs2_data = b2;
            e.rd       = in.rd;
            e.wb_en    = in.wb;
            e.prev     = arch_rf[in.rd];
            e.acc_cyc  = cyc;
            if (in.wb && in.rd != 5'd0) arch_rf[in.rd] = e.result;
            sb.push_back(e);
        end
        if (fl) rollback();
    endtask

    // Bench-side MEM and WB stages retire what EX hands over
    always @(posedge clk_i) begin
        if (w_valid && w_rd != 5'd0) phys_rf[w_rd] <= w_data;
        w_valid <= m_valid; w_rd <= m_rd; w_data <= m_data;
        m_valid <= fire_now && fire_wb; m_rd <= fire_rd; m_data <= fire_data;
        cyc <= cyc + 1;
    end

    // Monitor: the oldest in-flight instruction sits in EX/MEM once two edges have passed since acceptance
    initial begin
        logic exp_v;
        forever begin
            @(negedge clk_i);
            #1;
            fire_now = 1'b0;
            if (!rst_i) begin
                exp_v = (sb.size() > 0) && (cyc - sb[0].acc_cyc >= 2);
                checkOutput("ex_ready", {31'd0, ex_ready_o}, {31'd0, (sb.size() < 2) || mem_ready_i});
                checkOutput("mem_valid", {31'd0, mem_valid_o}, {31'd0, exp_v});
                if (exp_v && mem_valid_o) begin
                    checkOutput("result", mem_result_o, sb[0].result);
                    checkOutput("pc", mem_pc_o, sb[0].pc);
                    checkOutput("rs2_data", mem_rs2_data_o, sb[0].rs2_data);
                    checkOutput("rd", {27'd0, mem_rd_o}, {27'd0, sb[0].rd});
                    checkOutput("wb_en", {31'd0, mem_wb_en_o}, {31'd0, sb[0].wb_en});
                    if (mem_ready_i) begin
                        fire_now  = 1'b1;
                        fire_wb   = sb[0].wb_en;
                        fire_rd   = sb[0].rd;
                        fire_data = sb[0].result;
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_mem_valid"}, {31'd0, mem_valid_o}, 32'd0);
        checkOutput({tag, "_ex_ready"}, {31'd0, ex_ready_o}, 32'd1);
        checkOutput({tag, "_result"}, mem_result_o, 32'd0);
        checkOutput({tag, "_pc"}, mem_pc_o, 32'd0);
        checkOutput({tag, "_rs2_data"}, mem_rs2_data_o, 32'd0);
        checkOutput({tag, "_rd_wb"}, {26'd0, mem_rd_o, mem_wb_en_o}, 32'd0);
    endtask

    task automatic offer(input instr_t in, input bit allow_stall);
        logic acc;
        logic mr, fl;
        int   tries;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 20) begin
            mr = allow_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            fl = allow_stall && ($urandom_range(0, 99) < 3);
            if (fl) mr = 1'b0;
            applyStimulus(1'b1, in, mr, fl, acc);
            tries++;
        end
        if (!acc) checkOutput("accept_bound", 32'd0, 32'd1);
    endtask

    instr_t prog [12];
    instr_t nop_i, r;
    logic   dummy;

    initial begin
        nop_i = mk(4'b0000, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1);
        nop_i.wb = 1'b0;
        rst_i = 1'b1; flush_i = 1'b0; id_valid_i = 1'b0; mem_ready_i = 1'b0;
        id_pc_i = '0; id_rs1_i = '0; id_rs2_i = '0; id_rd_i = '0; id_rs1_data_i = '0;
        id_rs2_data_i = '0; id_imm_i = '0; id_alu_op_i = '0; id_src1_pc_i = 1'b0;
        id_src2_imm_i = 1'b0; id_wb_en_i = 1'b0;
        fmem_valid_i = 1'b0; fmem_rd_i = '0; fmem_data_i = '0;
        fwb_valid_i = 1'b0; fwb_rd_i = '0; fwb_data_i = '0;
        repeat (2) @(negedge clk_i);
        #1;
        checkResetOutputs("reset");
        @(negedge clk_i);
        rst_i = 1'b0;

        // Dependency chain, x0 guard and MEM-over-WB priority
        prog[0] = mk(4'b0000, 5'd0, 5'd0, 5'd1, 32'd5, 1'b1);
        prog[1] = mk(4'b0000, 5'd1, 5'd1, 5'd2, 32'd0, 1'b0);
        prog[2] = mk(4'b0000, 5'd0, 5'd0, 5'd0, 32'd7, 1'b1);
        prog[3] = mk(4'b0000, 5'd0, 5'd0, 5'd3, 32'd0, 1'b0);
        prog[4] = mk(4'b0000, 5'd0, 5'd0, 5'd4, 32'd2, 1'b1);
        prog[5] = mk(4'b0000, 5'd0, 5'd0, 5'd4, 32'd1, 1'b1);
        prog[6] = mk(4'b0000, 5'd0, 5'd0, 5'd6, 32'd0, 1'b1);
        prog[7] = mk(4'b0000, 5'd4, 5'd0, 5'd7, 32'd0, 1'b0);
        prog[8] = mk(4'b0000, 5'd0, 5'd0, 5'd3, 32'h55, 1'b1);
        prog[9] = mk(4'b0000, 5'd0, 5'd0, 5'd8, 32'd1, 1'b1);
        prog[10] = mk(4'b0000, 5'd0, 5'd0, 5'd9, 32'd2, 1'b1);
        prog[11] = mk(4'b0000, 5'd3, 5'd0, 5'd10, 32'd0, 1'b0);
        foreach (prog[i]) offer(prog[i], 1'b0);
        // Stall with the x3 consumer in S1 while its producer passes through WB
        repeat (3) applyStimulus(1'b0, nop_i, 1'b0, 1'b0, dummy);
        repeat (3) applyStimulus(1'b0, nop_i, 1'b1, 1'b0, dummy);

        // Fill both stages under backpressure, then flush while ID offers
        applyStimulus(1'b1, mk(4'b0100, 5'd1, 5'd2, 5'd5, 32'd0, 1'b0), 1'b0, 1'b0, dummy);
        applyStimulus(1'b1, mk(4'b0110, 5'd2, 5'd0, 5'd6, 32'h30, 1'b1), 1'b0, 1'b0, dummy);
        applyStimulus(1'b1, mk(4'b0000, 5'd0, 5'd0, 5'd7, 32'h99, 1'b1), 1'b0, 1'b1, dummy);
        checkOutput("flush_not_accepted", {31'd0, dummy}, 32'd0);
        repeat (3) applyStimulus(1'b0, nop_i, 1'b1, 1'b0, dummy);

        for (int n = 0; n < 300; n++) begin
            r.rs1 = 5'($urandom_range(0, 4)); r.rs2 = 5'($urandom_range(0, 4));
            r.rd = 5'($urandom_range(0, 4));
            r.op = op_tab[$urandom_range(0, 9)];
            r.imm = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
            r.pc = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
            r.s1pc = ($urandom_range(0, 7) == 0);
            r.s2imm = ($urandom_range(0, 2) == 0);
            r.wb = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 6) == 0) applyStimulus(1'b0, nop_i, $urandom_range(0, 3) != 0, 1'b0, dummy);
            offer(r, 1'b1);
            if (n == 150) begin
                // Asynchronous reset between edges drops everything in flight
                @(negedge clk_i);
                id_valid_i = 1'b0; mem_ready_i = 1'b0; flush_i = 1'b0;
                #3;
                rst_i = 1'b1;
                #1;
                checkResetOutputs("midreset");
                rollback();
                @(negedge clk_i);
                rst_i = 1'b0;
            end
        end

        for (int k = 0; k < 20 && sb.size() > 0; k++) applyStimulus(1'b0, nop_i, 1'b1, 1'b0, dummy);
        checkOutput("drain", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rv_ex_stage.md
# rv_ex_stage

Execute stage of the dv-cpu-rv integer pipeline. It registers decoded instructions from ID, selects ALU operands with forwarding, drives the `rv_alu` combinational unit, and registers the result into an EX/MEM register for the MEM stage. Valid/ready handshakes sit on both sides, and a flush input kills in-flight work.

## Interface

**Parameters**
- `XLEN`, 32: datapath width; matches `MXLEN`.

**Ports**
- `clk_i` in 1: clock. One clock domain; everything is rising-edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `flush_i` in 1: kill S1 and S2 contents this cycle.
- `id_valid_i` in 1: ID offers an instruction.
- `ex_ready_o` out 1: EX accepts this cycle.
- `id_pc_i` in XLEN: instruction PC.
- `id_rs1_i`, `id_rs2_i`, `id_rd_i` in 5 each: register indices.
- `id_rs1_data_i`, `id_rs2_data_i` in XLEN: register-file read data.
- `id_imm_i` in XLEN: sign-extended immediate.
- `id_alu_op_i` in 4: ALU op select, `rv_alu` encoding.
- `id_src1_pc_i` in 1: op1 = PC instead of rs1.
- `id_src2_imm_i` in 1: op2 = imm instead of rs2.
- `id_wb_en_i` in 1: instruction writes rd.
- `fmem_valid_i` in 1, `fmem_rd_i` in 5, `fmem_data_i` in XLEN: MEM-stage forward source.
- `fwb_valid_i` in 1, `fwb_rd_i` in 5, `fwb_data_i` in XLEN: WB-stage forward source.
- `mem_valid_o` out 1: EX/MEM register holds an instruction.
- `mem_ready_i` in 1: MEM accepts.
- `mem_pc_o` out XLEN, `mem_result_o` out XLEN, `mem_rs2_data_o` out XLEN (forwarded store data), `mem_rd_o` out 5, `mem_wb_en_o` out 1.

## Operation

**Stage registers**
- S1 (ID/EX) and S2 (EX/MEM), each with its own valid bit.
- `s2_adv = s1_valid & (~s2_valid | mem_ready_i)`.
- `ex_ready_o = ~s1_valid | s2_adv`.
- S1 loads when `id_valid_i & ex_ready_o`. Otherwise S1 clears its valid if `s2_adv` is set, or holds.
- S2 loads the ALU result when `s2_adv`. Otherwise S2 clears its valid if `mem_ready_i` is set, or holds.

**Forwarding**
- Forwarding is evaluated combinationally on the S1 rs1/rs2 fields.
- Priority: S2 (`s2_valid & s2_wb_en & s2_rd==rs`) > fmem > fwb > captured data.
- A source only qualifies when `rs != 0`; x0 is never forwarded.

**WB snoop**
- While S1 holds (valid and not advancing), a matching `fwb` updates the captured rs1/rs2 data register.
- Reason: the WB value vanishes after one cycle.

**Operands**
- `op1 = src1_pc ? pc : fwd_rs1`.
- `op2 = src2_imm ? imm : fwd_rs2`.
- `mem_rs2_data_o` always carries `fwd_rs2`.

**Flush**
- `flush_i` clears both valid bits at the next edge.
- `id_valid_i` is ignored that cycle.
- Flush has priority over load and advance.

**Reset**
- Every output is 0 and both valid bits are 0.
- `ex_ready_o` reads 1 during and after reset.
- Data registers are reset to 0.

## Timing

- Latency: an instruction accepted at edge N appears on `mem_valid_o` after edge N+1, i.e. two register stages.
- Throughput: one instruction per cycle while `mem_ready_i` = 1.
- `ex_ready_o` depends combinationally on `mem_ready_i`. There is no skid buffer.
- Outputs stay stable while `mem_valid_o & ~mem_ready_i`.
- Simultaneous `id_valid_i` accept and S2 advance in the same cycle is legal; both happen at one edge.
- Reset asserted mid-operation drops all in-flight instructions immediately (asynchronous).

## Structure

- Shared package/defines file: `MXLEN`, ALU op codes (ADD=0000, SUB=1000, SLL, SLT, SLTU, XOR, SRL, SRA=1101, OR, AND), register-index width.
- One sub-module instance: the existing `rv_alu`.
- A forwarding-mux helper, `rv_fwd_mux`, is natural and is used twice (rs1, rs2).

## Test plan

- **Back-to-back dependency:**
  - Stimulus: `addi x1,x0,5` then `add x2,x1,x1` (captured rs data 0), `mem_ready_i`=1.
  - Required: results 5 then 10; second result appears one cycle after the first.
- **x0 guard:**
  - Stimulus: S2 holds rd=x0 with result 7; next instruction reads x0.
  - Required: op uses 0, result 0.
- **Stall and WB snoop:**
  - Stimulus: hold `mem_ready_i`=0 for 3 cycles with S1 reading x3; pulse `fwb` x3 = 0x55 during the stall.
  - Required: after release, result uses 0x55; S2 outputs are unchanged during the stall; `ex_ready_o`=0.
- **Forward priority:**
  - Stimulus: `fmem` x4=1 and `fwb` x4=2 in the same cycle, S2 not matching.
  - Required: op uses 1.
- **Flush:**
  - Stimulus: both stages valid, `flush_i`=1 with `id_valid_i`=1.
  - Required: next cycle `mem_valid_o`=0, S1 empty, and the offered instruction is not accepted.
- **Async reset mid-stream:**
  - Stimulus: assert `rst_i` between edges.
  - Required: `mem_valid_o` drops to 0 immediately, `ex_ready_o`=1, and all data outputs are 0.
